// File: rtl/add32.sv
// -----------------------------------------------------------------------------
// add32 -- registered two's-complement adder for the datapath arithmetic unit.
//
// Sums a and b modulo 2^WIDTH through eight cascaded 4-bit carry-lookahead
// groups and registers the result one clock after a valid input.
//
// Ports:
//    clk         rising-edge clock
//    rst_n       asynchronous active-low reset (deassertion synchronous)
//    a, b        operands (unsigned or two's-complement)
//    in_valid    operands valid this cycle
//    add_result  registered sum (a + b) mod 2^WIDTH
//    out_valid   add_result / flags hold a new sum this cycle
//    carry       unsigned carry-out of the MSB
//    overflow    signed overflow
//    zero        add_result == 0
//    negative    add_result MSB
//
// Build option:
//    ADD_FLAGS_EN  defined   -> carry/overflow/zero/negative are registered
//                  undefined -> flag ports present but tied to 0
//
// Only WIDTH = 32 is required; WIDTH must be a multiple of 4.
// -----------------------------------------------------------------------------
module add32 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             in_valid,
   output logic [WIDTH-1:0] add_result,
   output logic             out_valid,
   output logic             carry,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);

   localparam int NGROUPS = WIDTH / 4;

   logic [WIDTH-1:0] g;     // bit generate
   logic [WIDTH-1:0] p;     // bit propagate
   logic [WIDTH:0]   c;     // carry into each bit, c[WIDTH] is carry-out
   logic [WIDTH-1:0] sum;

   assign g = a & b;
   assign p = a ^ b;

   // Lookahead inside each 4-bit group; group G/P ripple the carry on to the
   // next group. Built in one process so the carry vector is not a
   // self-referencing continuous assignment.
   always_comb begin : cla_chain
      logic [3:0] gg;
      logic [3:0] pp;
      logic       cin;
      logic       grp_g;
      logic       grp_p;
      // NOTE: every variable written here gets a value before any branch or
      // loop so no path leaves it unassigned, which would infer a latch.
      c     = '0;
      gg    = '0;
      pp    = '0;
      cin   = 1'b0;
      grp_g = 1'b0;
      grp_p = 1'b0;
      for (int k = 0; k < NGROUPS; k++) begin
         gg  = g[4*k +: 4];
         pp  = p[4*k +: 4];
         cin = c[4*k];
         c[4*k+1] = gg[0] | (pp[0] & cin);
         c[4*k+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cin);
         c[4*k+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                  | (pp[2] & pp[1] & pp[0] & cin);
         grp_g = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
               | (pp[3] & pp[2] & pp[1] & gg[0]);
         grp_p = &pp;
         c[4*k+4] = grp_g | (grp_p & cin);
      end
   end

   assign sum = p ^ c[WIDTH-1:0];

   // Result register: holds its value while in_valid is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         add_result <= '0;
         out_valid  <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         out_valid <= in_valid;
         if (in_valid) begin
            add_result <= sum;
         end
      end
   end

`ifdef ADD_FLAGS_EN
   logic flag_overflow_d;

   // Signed overflow: operands share a sign and the sum's sign differs.
   assign flag_overflow_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carry    <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b1;   // consistent with the reset result of 0
         negative <= 1'b0;
      end else if (in_valid) begin
         carry    <= c[WIDTH];
         overflow <= flag_overflow_d;
         zero     <= (sum == '0);
         negative <= sum[WIDTH-1];
      end
   end
`else
   // Carry-out is still produced by the chain but nothing consumes it.
   logic unused_carry_out;
   assign unused_carry_out = c[WIDTH];

   assign carry    = 1'b0;
   assign overflow = 1'b0;
   assign zero     = 1'b0;
   assign negative = 1'b0;
`endif

endmodule

// File: tb/tb_add32.sv
// -----------------------------------------------------------------------------
// tb_add32 -- scoreboard bench for add32.
//
// A driver applies operands on the falling edge and pushes the expected
// response (from an arithmetic reference model) into a queue; a monitor on
// the falling edge pops and compares whenever out_valid is high, and checks
// that outputs hold while out_valid is low.
// -----------------------------------------------------------------------------
module tb_add32;

   typedef struct packed {
      logic [31:0] res;
      logic        c;
      logic        o;
      logic        z;
      logic        n;
   } exp_t;

`ifdef ADD_FLAGS_EN
   localparam bit FLAGS = 1'b1;
`else
   localparam bit FLAGS = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic [31:0] a;
   logic [31:0] b;
   logic        in_valid;
   logic [31:0] add_result;
   logic        out_valid;
   logic        carry;
   logic        overflow;
   logic        zero;
   logic        negative;

   int checks = 0;
   int errors = 0;

   exp_t exp_q[$];
   exp_t last_exp;

   add32 #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .a          (a),
      .b          (b),
      .in_valid   (in_valid),
      .add_result (add_result),
      .out_valid  (out_valid),
      .carry      (carry),
      .overflow   (overflow),
      .zero       (zero),
      .negative   (negative)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: plain wide arithmetic, signed range test for overflow.
   function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
      exp_t        e;
      logic [63:0] us;
      longint      ss;
      us   = {32'd0, x} + {32'd0, y};
      ss   = longint'($signed(x)) + longint'($signed(y));
      e.res = us[31:0];
      e.c   = FLAGS & us[32];
      e.o   = FLAGS & ((ss > 64'sd2147483647) || (ss < -64'sd2147483648));
      e.z   = FLAGS & (us[31:0] == 32'd0);
      e.n   = FLAGS & us[31];
      return e;
   endfunction

   function automatic exp_t reset_exp();
      exp_t e;
      e     = '0;
      e.z   = FLAGS;
      return e;
   endfunction

   task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic v);
      @(negedge clk);
      a        = x;
      b        = y;
      in_valid = v;
      if (v) exp_q.push_back(model(x, y));
   endtask

   // Monitor: compare against the scoreboard on valid, check hold otherwise.
   initial begin
      exp_t e;
      last_exp = reset_exp();
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (out_valid) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_out_valid", 64'(out_valid), 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("add_result", 64'(add_result), 64'(e.res));
                  check("flags_cozn", 64'({carry, overflow, zero, negative}),
                        64'({e.c, e.o, e.z, e.n}));
                  last_exp = e;
               end
            end else begin
               check("hold_result", 64'(add_result), 64'(last_exp.res));
               check("hold_flags", 64'({carry, overflow, zero, negative}),
                     64'({last_exp.c, last_exp.o, last_exp.z, last_exp.n}));
            end
         end
      end
   end

   initial begin
      exp_t r;
      int   wait_cycles;
      r        = reset_exp();
      rst_n    = 1'b0;
      a        = '0;
      b        = '0;
      in_valid = 1'b0;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check("reset_result", 64'(add_result), 64'd0);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_flags", 64'({carry, overflow, zero, negative}), 64'({r.c, r.o, r.z, r.n}));
      @(negedge clk);
      #2 rst_n = 1'b1;

      // Incrementing sweep: a steps every cycle, b every second cycle; wraps.
      for (int i = 0; i < 72; i++) begin
         drive(32'(i) * 32'h0400_0000, 32'(i / 2) * 32'h0400_0000, 1'b1);
      end

      // Boundary cases.
      drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
      drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
      drive(32'h8000_0000, 32'h8000_0000, 1'b1);
      drive(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      drive(32'h0000_0000, 32'h0000_0000, 1'b1);

      // Valid gating: operands change with in_valid low, outputs must hold.
      for (int i = 0; i < 4; i++) drive($urandom, $urandom, 1'b0);
      drive(32'h1234_5678, 32'h1111_1111, 1'b1);
      drive($urandom, $urandom, 1'b0);

      // Randomised traffic with random valid gaps.
      for (int i = 0; i < 300; i++) begin
         drive($urandom, $urandom, 1'($urandom_range(0, 3) != 0));
      end

      // Mid-cycle reset discards the in-flight sum and clears at once.
      drive(32'hDEAD_0000, 32'h0000_BEEF, 1'b1);
      @(posedge clk);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("midreset_result", 64'(add_result), 64'd0);
      check("midreset_out_valid", 64'(out_valid), 64'd0);
      check("midreset_flags", 64'({carry, overflow, zero, negative}), 64'({r.c, r.o, r.z, r.n}));
      exp_q.delete();
      last_exp = r;
      @(negedge clk);
      #2 rst_n = 1'b1;

      // First capture after reset release, then a short random burst.
      drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
      for (int i = 0; i < 20; i++) drive($urandom, $urandom, 1'b1);
      drive('0, '0, 1'b0);

      // Drain with a bounded wait.
      wait_cycles = 0;
      while (exp_q.size() != 0 && wait_cycles < 10) begin
         @(negedge clk);
         wait_cycles++;
      end
      @(negedge clk);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
